// File: rtl/shubham_fifo.sv
// shubham_fifo
//   Single-clock FIFO for 2D pipeline command words. DEPTH entries of
//   DATA_WIDTH bits, registered read data, full/empty decoded from the
//   registered occupancy count. Writes when full and reads when empty are
//   ignored, so stored contents are never disturbed.
//
// Ports
//   clk       rising-edge clock
//   n_rst     asynchronous reset, active HIGH despite the name
//   w_enable  write request; accepted when !full
//   w_data    word written on an accepted write
//   r_enable  read request; accepted when !empty
//   r_data    word popped by the most recent accepted read (held otherwise)
//   empty     count == 0
//   full      count == DEPTH
module shubham_fifo #(
   parameter int DATA_WIDTH = 83,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  w_enable,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_enable,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  empty,
   output logic                  full
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
   logic [AW-1:0]                    wptr, rptr;
   logic [AW:0]                      count;
   logic                             wr_ok, rd_ok;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // Accept decisions use the flags as they stood before the edge, so a
   // read on empty never falls through to a same-cycle write.
   assign wr_ok = w_enable && !full;
   assign rd_ok = r_enable && !empty;

   // Storage is not reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= w_data;
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         r_data <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (rd_ok) begin
            r_data <= mem[rptr];
            rptr   <= rptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_shubham_fifo.sv
// tb_shubham_fifo
//   Directed bench for shubham_fifo: reset, fill/drain, overflow and
//   underflow, ordering, pointer wrap, simultaneous read/write and
//   asynchronous reset mid-stream.
module tb_shubham_fifo;

   localparam int W = 83;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         w_enable;
   logic [W-1:0] w_data;
   logic         r_enable;
   logic [W-1:0] r_data;
   logic         empty, full;

   int total = 0;
   int bad   = 0;

   shubham_fifo #(.DATA_WIDTH(W), .DEPTH(4)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .w_enable (w_enable),
      .w_data   (w_data),
      .r_enable (r_enable),
      .r_data   (r_data),
      .empty    (empty),
      .full     (full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // advance one edge, land 1 time unit after it
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [W-1:0] d);
      w_enable = 1'b1;
      w_data   = d;
      cyc();
      w_enable = 1'b0;
   endtask

   task automatic rd();
      r_enable = 1'b1;
      cyc();
      r_enable = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ones, alt, va, vb, vc, v;
      ones = '1;
      alt  = '0;
      for (int i = 0; i < W; i++) alt[i] = (i % 2 == 0);
      alt[1] = 1'b1;                      // ...10111
      va = 83'h12345_6789ABCD_EF012345;
      vb = 83'h2FEDC_BA987654_3210FEDC;
      vc = 83'h00000_00000000_0000C0DE;

      n_rst = 1'b1; w_enable = 1'b0; r_enable = 1'b0; w_data = '0;
      #2;
      chk("rst_empty", empty, 1'b1);
      chk("rst_full",  full,  1'b0);
      chk("rst_rdata", r_data, '0);
      cyc(); cyc();
      n_rst = 1'b0;

      // single write / read of all ones
      wr(ones);
      chk("w1_empty", empty, 1'b0);
      rd();
      chk("r1_data",  r_data, ones);
      chk("r1_empty", empty, 1'b1);

      // fill with idle gaps, then one overflow attempt
      for (int i = 0; i < 4; i++) begin
         wr(ones);
         cyc();
         if (i == 2) chk("fill3_full", full, 1'b0);
      end
      chk("fill_full",  full,  1'b1);
      chk("fill_empty", empty, 1'b0);
      wr(83'h5);                          // must be dropped
      chk("ovf_full", full, 1'b1);

      // drain 4, then one underflow attempt
      for (int i = 0; i < 4; i++) begin
         rd();
         chk("drain_data", r_data, ones);
         if (i == 0) chk("drain1_full", full, 1'b0);
         if (i == 2) chk("drain3_empty", empty, 1'b0);
      end
      chk("drain_empty", empty, 1'b1);
      rd();
      chk("udf_hold", r_data, ones);
      chk("udf_empty", empty, 1'b1);

      // alternating pattern, held after r_enable drops
      wr(alt);
      rd();
      chk("alt_data", r_data, alt);
      cyc();
      chk("alt_hold", r_data, alt);

      // ordering
      wr(va); wr(vb); wr(vc);
      rd(); chk("ord_a", r_data, va);
      rd(); chk("ord_b", r_data, vb);
      rd(); chk("ord_c", r_data, vc);
      chk("ord_empty", empty, 1'b1);

      // six write/read pairs so both pointers wrap
      for (int i = 0; i < 6; i++) begin
         v = 83'h40000_00000000_00000000 | W'(i + 1);
         wr(v);
         rd();
         chk("wrap_data", r_data, v);
      end

      // count=2, both enables for 3 cycles
      wr(83'hD0); wr(83'hD1);
      w_enable = 1'b1; r_enable = 1'b1;
      w_data = 83'hE0; cyc(); chk("sim1", r_data, 83'hD0);
      w_data = 83'hE1; cyc(); chk("sim2", r_data, 83'hD1);
      w_data = 83'hE2; cyc(); chk("sim3", r_data, 83'hE0);
      w_enable = 1'b0; r_enable = 1'b0;
      chk("sim_full", full, 1'b0);
      rd(); chk("sim_e1", r_data, 83'hE1);
      chk("sim_cnt1", empty, 1'b0);
      rd(); chk("sim_e2", r_data, 83'hE2);
      chk("sim_cnt0", empty, 1'b1);

      // both at empty: only the write goes in
      w_enable = 1'b1; r_enable = 1'b1; w_data = 83'hF0;
      cyc();
      w_enable = 1'b0; r_enable = 1'b0;
      chk("emp_both_empty", empty, 1'b0);
      chk("emp_both_rdata", r_data, 83'hE2);

      // fill to 4, then both at full: only the read goes in
      wr(83'hA1); wr(83'hA2); wr(83'hA3);
      chk("full_again", full, 1'b1);
      w_enable = 1'b1; r_enable = 1'b1; w_data = 83'hBB;
      cyc();
      w_enable = 1'b0; r_enable = 1'b0;
      chk("full_both_rdata", r_data, 83'hF0);
      chk("full_both_full",  full, 1'b0);
      rd(); chk("cnt3_a1", r_data, 83'hA1);
      rd(); chk("cnt3_a2", r_data, 83'hA2);
      chk("cnt3_notempty", empty, 1'b0);
      rd(); chk("cnt3_a3", r_data, 83'hA3);
      chk("cnt3_empty", empty, 1'b1);

      // async reset between edges with count=3
      wr(83'h31); wr(83'h32); wr(83'h33);
      rd();                               // r_data = 31, count 2
      wr(83'h34);                         // count 3
      #3;
      n_rst = 1'b1;
      #1;
      chk("arst_empty", empty, 1'b1);
      chk("arst_full",  full,  1'b0);
      chk("arst_rdata", r_data, '0);
      cyc();
      n_rst = 1'b0;
      wr(83'h77);
      rd();
      chk("post_rst_data",  r_data, 83'h77);
      chk("post_rst_empty", empty, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
